ring_arbiter: RTL and testbench
===============================

// Module: ring_arbiter
// PURPOSE
//   Round-robin arbiter sharing one resource among WIDTH requesters.
//   Priority is a one-hot ring pointer that rotates past each winner, so the last owner gets lowest priority.
//   Grants are registered and one-hot, and are held until the owner releases the resource.
//   Sits in front of any shared datapath (bus, memory port, counter bank) whose users need exclusive access.
// PARAMETERS
//   WIDTH    4   number of requesters; grant/req width; >=2
//   TIMEOUT  15  max BUSY cycles before forced release (ARB_TIMEOUT_EN only); >=1
//   IW       $clog2(WIDTH)  owner index width (localparam)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      async, active-low reset
//   req      in   WIDTH  request per requester, level-sensitive
//   done     in   1      current owner releases resource (sampled in BUSY only)
//   grant    out  WIDTH  one-hot grant, registered; 0 when idle
//   busy     out  1      1 while any grant is active (== |grant)
//   owner    out  IW     binary index of granted requester; valid while busy
//   timeout  out  1      1-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset (rst=0, async): grant=0, busy=0, owner=0, timeout=0, ptr=1 (one-hot, bit0), state=IDLE.
//   FSM: IDLE, BUSY.
//   IDLE: if |req at posedge, winner = first set req bit scanning from ptr upward with wrap (MSB->bit0).
//     The winner's grant, owner and busy take effect after that edge (1-cycle latency); next state BUSY.
//     If req==0, stay IDLE with grant=0. done is ignored in IDLE.
//   BUSY: grant held constant; other req changes are ignored.
//     Release at posedge when done=1 OR req[owner]=0.
//     On release: grant=0, busy=0, state=IDLE, ptr = winner rotated left by 1 (bit WIDTH-1 wraps to bit0).
//     owner keeps its last value.
//     One IDLE bubble cycle always follows a release, so back-to-back grants are 2 cycles apart.
//   ptr changes only on release, never while idle, so an idle gap does not change fairness.
//   Invariants: grant is one-hot or zero; owner == index(grant) while busy.
//     No requester is granted twice while another continuously requests.
//   Reset asserted mid-BUSY: grant drops immediately (async); ptr returns to 1.
//   Reset release: first arbitration happens at the first posedge with rst=1.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     Counter of width $clog2(TIMEOUT+1) clears on entry to BUSY and increments each BUSY cycle.
//     If it reaches TIMEOUT without a release: forced release as above, with timeout=1 for exactly that cycle.
//     done/req release in the same cycle takes precedence (timeout stays 0).
//   ARB_TIMEOUT_EN undefined:
//     No counter; timeout is constant 0; the owner can hold the resource indefinitely.
// TESTING (WIDTH=4 unless noted)
//   1 Reset: rst=0 -> grant=0000, busy=0, owner=0. Then rst=1 with req=0000 for 3 cycles -> grant stays 0000.
//   2 Single grant: req=0001 -> grant=0001, owner=0 one edge later.
//     done=1 one cycle -> grant=0000 next edge; next winner search starts at bit1.
//   3 Rotation/wrap: req=1111 held, done=1 whenever busy -> grants 0001,0010,0100,1000,0001 with a 0000 cycle between each.
//   4 Fairness: after serving 1000, req=1001 -> grant=0001. After serving 0001, req=1001 -> grant=1000.
//   5 Drop release: grant=0100, req falls to 0000 with done=0 -> grant=0000 next edge, ptr=1000.
//   6 Async reset mid-BUSY: grant=0010, rst pulsed low between edges -> grant=0000 before the next edge.
//     After rst=1 with req=1111 -> grant=0001.
//   7 ARB_TIMEOUT_EN, TIMEOUT=4: req=0100 held, done=0 -> grant=0100 for 4 cycles, then 0000 with timeout=1 for one cycle.

Source files
------------

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer.
// Grants are registered, one-hot, and held until the owner releases them.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
module ring_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 15,
   localparam int unsigned IW     = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] req_i,
   input  logic             done_i,
   output logic [WIDTH-1:0] grant_o,
   output logic             busy_o,
   output logic [IW-1:0]    owner_o,
   output logic             timeout_o
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   grant_q, grant_d;
   logic [WIDTH-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic               timeout_q, timeout_d;

   // Winner search scratch
   logic [IW-1:0]      ptr_idx;
   logic [IW:0]        scan_idx;
   logic               found;
   logic [WIDTH-1:0]   win_grant;
   logic [IW-1:0]      win_owner;

   // Elaboration-time parameter sanity checks
   if (WIDTH < 2) begin : g_bad_width
      $error("ring_arbiter: WIDTH must be >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("ring_arbiter: TIMEOUT must be >= 1");
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // First requester at or above the pointer, wrapping MSB -> bit0
   always_comb begin
      ptr_idx   = '0;
      scan_idx  = '0;
      found     = 1'b0;
      win_grant = '0;
      win_owner = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ptr_q[i]) ptr_idx = IW'(i);
      end
      for (int i = 0; i < WIDTH; i++) begin
         scan_idx = {1'b0, ptr_idx} + (IW + 1)'(i);
         if (scan_idx >= (IW + 1)'(WIDTH)) scan_idx = scan_idx - (IW + 1)'(WIDTH);
         if (!found && req_i[scan_idx[IW-1:0]]) begin
            found                          = 1'b1;
            win_grant[scan_idx[IW-1:0]]    = 1'b1;
            win_owner                      = scan_idx[IW-1:0];
         end
      end
   end

   // Next-state logic: arbitrate in idle, hold and watch for release in busy
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = win_grant;
               owner_d = win_owner;
               state_d = StBusy;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         StBusy: begin
            if (done_i || !req_i[owner_q]) begin
               grant_d = '0;
               ptr_d   = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
               state_d = StIdle;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Owner overstayed: forced release, same pointer rotation
               grant_d   = '0;
               ptr_d     = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
               state_d   = StIdle;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers, async active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         ptr_q     <= WIDTH'(1);
         owner_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Busy-cycle counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign grant_o = grant_q;
   assign busy_o  = |grant_q;
   assign owner_o = owner_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter (WIDTH=4, TIMEOUT=4) with an expectation queue.
module tb_ring_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       busy;
   logic [1:0] owner;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] owner;
      logic       tmo;
      string      tag;
   } exp_t;

   exp_t sb[$];

   ring_arbiter #(.WIDTH(4), .TIMEOUT(4)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req),
      .done_i   (done),
      .grant_o  (grant),
      .busy_o   (busy),
      .owner_o  (owner),
      .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired: got=no-finish exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [3:0] g, input logic [1:0] o, input logic t, input string tag);
      exp_t e;
      e.grant = g;
      e.owner = o;
      e.tmo   = t;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL scoreboard_empty got=0 exp=>0");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         assert (grant === e.grant) else begin
            bad++;
            $error("FAIL %s.grant got=%b exp=%b", e.tag, grant, e.grant);
         end
         total++;
         assert (busy === (|e.grant)) else begin
            bad++;
            $error("FAIL %s.busy got=%b exp=%b", e.tag, busy, |e.grant);
         end
         total++;
         assert (owner === e.owner) else begin
            bad++;
            $error("FAIL %s.owner got=%0d exp=%0d", e.tag, owner, e.owner);
         end
         total++;
         assert (timeout === e.tmo) else begin
            bad++;
            $error("FAIL %s.timeout got=%b exp=%b", e.tag, timeout, e.tmo);
         end
      end
   endtask

   // Push the expectation for the next edge, then sample 1 time unit after it
   task automatic tick(input logic [3:0] g, input logic [1:0] o, input logic t, input string tag);
      push(g, o, t, tag);
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;

      // 1 reset
      repeat (2) @(posedge clk);
      #1;
      push(4'b0000, 2'd0, 1'b0, "reset");
      check();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick(4'b0000, 2'd0, 1'b0, "idle_noreq");

      // 2 single grant, then release moves search start to bit1
      req = 4'b0001;
      tick(4'b0001, 2'd0, 1'b0, "single_grant");
      done = 1'b1;
      tick(4'b0000, 2'd0, 1'b0, "single_done");
      done = 1'b0;
      req  = 4'b0011;
      tick(4'b0010, 2'd1, 1'b0, "search_from_bit1");

      // 3 rotation with wrap, done held high
      req  = 4'b1111;
      done = 1'b1;
      tick(4'b0000, 2'd1, 1'b0, "rot_rel1");
      tick(4'b0100, 2'd2, 1'b0, "rot_g2");
      tick(4'b0000, 2'd2, 1'b0, "rot_rel2");
      tick(4'b1000, 2'd3, 1'b0, "rot_g3");
      tick(4'b0000, 2'd3, 1'b0, "rot_rel3");
      tick(4'b0001, 2'd0, 1'b0, "rot_wrap_g0");
      tick(4'b0000, 2'd0, 1'b0, "rot_rel0");
      tick(4'b0010, 2'd1, 1'b0, "rot_g1");
      done = 1'b0;
      req  = 4'b0000;
      tick(4'b0000, 2'd1, 1'b0, "rot_drop");

      // 4 fairness between bit3 and bit0; busy ignores other requests
      req = 4'b1000;
      tick(4'b1000, 2'd3, 1'b0, "fair_g3");
      req = 4'b1111;
      tick(4'b1000, 2'd3, 1'b0, "busy_hold");
      done = 1'b1;
      tick(4'b0000, 2'd3, 1'b0, "fair_rel3");
      done = 1'b0;
      req  = 4'b1001;
      tick(4'b0001, 2'd0, 1'b0, "fair_after3");
      done = 1'b1;
      tick(4'b0000, 2'd0, 1'b0, "fair_rel0");
      done = 1'b0;
      tick(4'b1000, 2'd3, 1'b0, "fair_after0");
      done = 1'b1;
      tick(4'b0000, 2'd3, 1'b0, "fair_rel3b");
      done = 1'b0;

      // 5 request drop releases; pointer lands on bit3
      req = 4'b0100;
      tick(4'b0100, 2'd2, 1'b0, "drop_g2");
      req = 4'b0000;
      tick(4'b0000, 2'd2, 1'b0, "drop_rel");
      req = 4'b1111;
      tick(4'b1000, 2'd3, 1'b0, "drop_ptr3");
      done = 1'b1;
      tick(4'b0000, 2'd3, 1'b0, "drop_rel3");
      done = 1'b0;

      // 6 async reset mid-busy
      req = 4'b0010;
      tick(4'b0010, 2'd1, 1'b0, "arst_g1");
      #2;
      rst_n = 1'b0;
      #1;
      push(4'b0000, 2'd0, 1'b0, "arst_immediate");
      check();
      #1;
      rst_n = 1'b1;
      req   = 4'b1111;
      tick(4'b0001, 2'd0, 1'b0, "arst_after");
      done = 1'b1;
      tick(4'b0000, 2'd0, 1'b0, "arst_rel");
      done = 1'b0;

`ifdef ARB_TIMEOUT_EN
      // 7 forced release after 4 busy cycles
      req = 4'b0100;
      tick(4'b0100, 2'd2, 1'b0, "to_g2");
      for (int i = 0; i < 3; i++) tick(4'b0100, 2'd2, 1'b0, "to_hold");
      tick(4'b0000, 2'd2, 1'b1, "to_fire");
      tick(4'b0100, 2'd2, 1'b0, "to_regrant");
      for (int i = 0; i < 3; i++) tick(4'b0100, 2'd2, 1'b0, "to_hold2");
      done = 1'b1;
      tick(4'b0000, 2'd2, 1'b0, "to_done_wins");
      done = 1'b0;
      req  = 4'b0000;
      tick(4'b0000, 2'd2, 1'b0, "to_idle");
`else
      // Without the timeout the owner holds indefinitely
      req = 4'b0100;
      tick(4'b0100, 2'd2, 1'b0, "hold_g2");
      for (int i = 0; i < 20; i++) tick(4'b0100, 2'd2, 1'b0, "hold_long");
      req = 4'b0000;
      tick(4'b0000, 2'd2, 1'b0, "hold_rel");
`endif

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
